ni_frame_ctrl: RTL and testbench
================================

// Module: ni_frame_ctrl
// PURPOSE
//  Sequencer for the NI descriptor datapath (8 x NI_calc bit generators).
//  - Accepts one window per cycle from the upstream S1..S8/sum stage under valid/ready.
//  - Raster-counts the frame and strobes the datapath done input for interior pixels only.
//  - Re-merges datapath results with zero codes for border pixels, in raster order.
//  - Packs bit1..bit8 into a byte stream through a credit-protected FIFO.
//  - Signals frame completion to the NI progress_done input.
// PARAMETERS
//  IMG_W       640  pixels per row
//  IMG_H       480  rows per frame
//  BORDER      2    window radius; pixels closer than this to any edge are border pixels
//  NI_LAT      2    cycles from the ni_done_o edge to the matching ni_done_i / ni_bits_i
//  FIFO_DEPTH  4    output code FIFO entries, power of 2, >= 2
//  CW          10   row/column counter width, >= clog2(max(IMG_W, IMG_H))
// PORTS
//  clk            in   1   clock, all logic is rising-edge triggered
//  rst            in   1   asynchronous, active-low reset
//  start_i        in   1   one-cycle pulse: begin a frame (honoured only in IDLE)
//  pix_valid_i    in   1   upstream window valid
//  pix_ready_o    out  1   window accepted when pix_valid_i & pix_ready_o
//  ni_done_o      out  1   to NI done_i: interior window is present on S*/sum
//  ni_progress_o  out  1   to NI progress_done_i: end-of-frame pulse
//  ni_done_i      in   1   from NI done_o: ni_bits_i is valid
//  ni_bits_i      in   8   {bit8..bit1}; bit1 is at the LSB
//  code_o         out  8   FIFO head code
//  code_valid_o   out  1   FIFO not empty
//  code_ready_i   in   1   downstream pop; a pop occurs when code_valid_o & code_ready_i
//  busy_o         out  1   high in every state except IDLE
//  frame_done_o   out  1   one-cycle pulse, coincident with ni_progress_o
//  sync_err_o     out  1   sticky datapath/tag mismatch flag
// BEHAVIOUR
//  Reset (rst=0, takes effect immediately):
//  - state=IDLE; counters, tag pipe and FIFO are cleared.
//  - All outputs are 0, including sync_err_o and code_o.
//  FSM:
//  - IDLE -> RUN on start_i. Entering RUN clears row, col and sync_err_o.
//  - RUN -> DRAIN on acceptance of pixel (row=IMG_H-1, col=IMG_W-1).
//  - DRAIN -> DONE once the tag pipe is empty and the FIFO is empty.
//  - DONE -> IDLE after one cycle. ni_progress_o and frame_done_o are high only in DONE.
//  - start_i is ignored outside IDLE.
//  Acceptance (RUN only):
//  - pix_ready_o = (state==RUN) & (fifo_count + tags_in_flight < FIFO_DEPTH).
//  - pix_ready_o is 0 in IDLE, DRAIN and DONE.
//  - Each accept advances col. At col=IMG_W-1, col wraps to 0 and row increments.
//  - Interior pixel: BORDER <= row <= IMG_H-1-BORDER and BORDER <= col <= IMG_W-1-BORDER.
//  Tag pipe (depth NI_LAT+1), one entry per accepted pixel: {valid, interior}.
//  - ni_done_o is registered: high exactly one cycle after accepting an interior pixel.
//  - Upstream holds the window registers for that cycle.
//  - At pipe exit, interior entry: push ni_bits_i. Border entry: push 8'h00.
//  - Border codes are pushed in the same cycle they would have arrived, so raster order is kept.
//  - Latency: accept at cycle t -> FIFO write at t+1+NI_LAT -> code_valid_o at t+2+NI_LAT
//    (FIFO previously empty).
//  sync_err_o is set, and held until the next start_i, when:
//  - an interior tag exits while ni_done_i=0, or
//  - ni_done_i=1 and no interior tag exits.
//  - On a mismatch the push still occurs (ni_bits_i for an interior tag), so the code count is preserved.
//  FIFO:
//  - Show-ahead; code_o is the head entry.
//  - Simultaneous push and pop are legal at any fill level, including full and empty.
//  - The credit rule guarantees no overflow. Popping while empty is impossible (code_valid_o=0).
//  - code_valid_o may stall indefinitely; the frame then waits in RUN/DRAIN.
//  - A frame emits exactly IMG_W*IMG_H codes.
//  Reset mid-frame: the frame is abandoned, no frame_done_o is generated, and the FIFO contents are discarded.
// TESTING
//  Config for all scenarios: IMG_W=6, IMG_H=5, BORDER=1, NI_LAT=2, FIFO_DEPTH=4.
//  1 Basic frame. start, pix_valid_i=1 always, code_ready_i=1, NI model returns bits=row*16+col.
//    -> 30 codes; border codes are 0x00; pixel (1,1) gives 0x11.
//    -> 12 ni_done_o pulses; frame_done_o exactly once.
//  2 Backpressure. code_ready_i=0 from the start.
//    -> exactly 4 pixels accepted, then pix_ready_o=0.
//    -> raise code_ready_i: stream resumes with no code lost or duplicated.
//  3 Sync fault. NI model drops ni_done_i for pixel (2,3).
//    -> sync_err_o=1 from that cycle onward; 30 codes still emitted.
//    -> the next start_i clears sync_err_o.
//  4 Reset mid-frame. Assert rst after 10 accepts.
//    -> all outputs 0 immediately; then a new start gives a clean 30-code frame.
//  5 Start in RUN. Pulse start_i in RUN and DRAIN -> no effect.
//    Random pix_valid_i (50%) -> 30 codes, order preserved.

Source files
------------

// File: rtl/ni_frame_ctrl.sv
// Frame sequencer for the NI descriptor datapath: raster count,
// interior strobes, border code merge and credit-protected code FIFO.
module ni_frame_ctrl #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int BORDER     = 2,
    parameter int NI_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pix_valid_i,
    output logic       pix_ready_o,
    output logic       ni_done_o,
    output logic       ni_progress_o,
    input  logic       ni_done_i,
    input  logic [7:0] ni_bits_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    input  logic       code_ready_i,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       sync_err_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] ROW_LO   = CW'(BORDER);
    localparam logic [CW-1:0] ROW_HI   = CW'(IMG_H - 1 - BORDER);
    localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
    localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - 1 - BORDER);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            err_q, err_d;
    logic [NI_LAT:0] tv_q, ti_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [AW:0]     cnt_q, cnt_d;

    logic            accept;
    logic            interior;
    logic [7:0]      tags_n;
    logic [7:0]      credit;
    logic            exit_v, exit_int;
    logic            push, pop;
    logic [7:0]      push_data;

    // Tags still in the pipe each hold a future FIFO slot.
    always_comb begin
        tags_n = '0;
        for (int i = 0; i <= NI_LAT; i++) begin
            tags_n = tags_n + 8'(tv_q[i]);
        end
    end

    assign credit      = 8'(cnt_q) + tags_n;
    assign pix_ready_o = (state_q == RUN) && (credit < 8'(FIFO_DEPTH));
    assign accept      = pix_valid_i & pix_ready_o;

    assign interior = (row_q >= ROW_LO) && (row_q <= ROW_HI) &&
                      (col_q >= COL_LO) && (col_q <= COL_HI);

    assign exit_v    = tv_q[NI_LAT];
    assign exit_int  = tv_q[NI_LAT] & ti_q[NI_LAT];
    assign push      = exit_v;
    assign push_data = exit_int ? ni_bits_i : 8'h00;
    assign pop       = code_valid_o & code_ready_i;
    assign cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);

    assign ni_done_o     = tv_q[0] & ti_q[0];
    assign code_valid_o  = (cnt_q != '0);
    assign code_o        = code_valid_o ? mem_q[rp_q] : 8'h00;
    assign busy_o        = (state_q != IDLE);
    assign ni_progress_o = (state_q == DONE);
    assign frame_done_o  = (state_q == DONE);
    assign sync_err_o    = err_q;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = err_q | (exit_int ^ ni_done_i);
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tags_n == 8'd0 && cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            tv_q    <= '0;
            ti_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            tv_q    <= {tv_q[NI_LAT-1:0], accept};
            ti_q    <= {ti_q[NI_LAT-1:0], accept & interior};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem_q[wp_q] <= push_data;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ni_frame_ctrl.sv
// Directed bench for ni_frame_ctrl: NI latency model plus
// a raster-order scoreboard of expected codes.
module tb_ni_frame_ctrl;

    localparam int W = 6;
    localparam int H = 5;
    localparam int B = 1;
    localparam int L = 2;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic       pix_ready_o;
    logic       ni_done_o;
    logic       ni_progress_o;
    logic       ni_done_i = 1'b0;
    logic [7:0] ni_bits_i = 8'h00;
    logic [7:0] code_o;
    logic       code_valid_o;
    logic       code_ready_i = 1'b0;
    logic       busy_o;
    logic       frame_done_o;
    logic       sync_err_o;

    ni_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .BORDER(B),
        .NI_LAT(L), .FIFO_DEPTH(D), .CW(10)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
        .ni_done_o(ni_done_o), .ni_progress_o(ni_progress_o),
        .ni_done_i(ni_done_i), .ni_bits_i(ni_bits_i),
        .code_o(code_o), .code_valid_o(code_valid_o),
        .code_ready_i(code_ready_i), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .sync_err_o(sync_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] seen [W*H];
    int trow, tcol;
    int n_acc, n_codes, n_done, n_frame;
    int cyc = 0;
    int first_acc, first_code, err_cyc, drop_acc;
    int drop_r = -1;
    int drop_c = -1;
    logic rnd = 1'b0;
    logic ii, p_drop, d1, d2;
    logic [7:0] p_bits, b1, b2, e;

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) pix_valid_i = 1'($urandom_range(0, 1));
        end
    end

    // NI model, acceptance tracker and code scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            d1 = 0; d2 = 0; b1 = 0; b2 = 0;
            p_bits = 0; p_drop = 0;
            ni_done_i = 0; ni_bits_i = 0;
        end else begin
            ni_done_i = d2;
            ni_bits_i = b2;
            d2 = d1;
            b2 = b1;
            d1 = ni_done_o & ~p_drop;
            b1 = p_bits;
            if (ni_done_o) n_done++;
            p_bits = 8'h00;
            p_drop = 1'b0;
            if (pix_valid_i && pix_ready_o) begin
                ii = (trow >= B) && (trow <= H-1-B) &&
                     (tcol >= B) && (tcol <= W-1-B);
                p_bits = ii ? 8'(trow*16 + tcol) : 8'h00;
                p_drop = (trow == drop_r) && (tcol == drop_c);
                if (p_drop) drop_acc = cyc;
                exp_q.push_back(p_bits);
                if (n_acc == 0) first_acc = cyc;
                n_acc++;
                if (tcol == W-1) begin
                    tcol = 0;
                    trow++;
                end else begin
                    tcol++;
                end
            end
            if (code_valid_o && first_code < 0) first_code = cyc;
            if (sync_err_o && err_cyc < 0) err_cyc = cyc;
            if (code_valid_o && code_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $error("FAIL code_extra: observed %0h expected none",
                           code_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("code", {24'h0, code_o}, {24'h0, e});
                    if (n_codes < W*H) seen[n_codes] = code_o;
                    n_codes++;
                end
            end
            if (frame_done_o) begin
                n_frame++;
                chk("progress", {31'h0, ni_progress_o}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        exp_q.delete();
        trow = 0; tcol = 0;
        n_acc = 0; n_codes = 0; n_done = 0; n_frame = 0;
        first_acc = -1; first_code = -1;
        err_cyc = -1; drop_acc = -1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_frame >= 1) break;
            tick();
        end
        chk("frame_seen", n_frame, 32'd1);
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_acc >= n) break;
            tick();
        end
        chk("acc_reached", n_acc, n);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {16'h0, pix_ready_o, ni_done_o, ni_progress_o,
                  code_valid_o, busy_o, frame_done_o, sync_err_o,
                  1'b0, code_o}, 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        chk_zero("reset_outputs");
        rst = 1'b1;
        tick();

        // basic frame
        code_ready_i = 1'b1;
        pix_valid_i  = 1'b1;
        do_start();
        chk("busy_run", {31'h0, busy_o}, 32'd1);
        wait_frame(500);
        repeat (3) tick();
        chk("s1_codes", n_codes, 32'd30);
        chk("s1_ni_done", n_done, 32'd12);
        chk("s1_frames", n_frame, 32'd1);
        chk("s1_code00", {24'h0, seen[0]}, 32'h00);
        chk("s1_code11", {24'h0, seen[7]}, 32'h11);
        chk("s1_code12", {24'h0, seen[8]}, 32'h12);
        chk("s1_code_border", {24'h0, seen[11]}, 32'h00);
        chk("s1_latency", first_code - first_acc, 32'd4);
        chk("s1_sync_err", {31'h0, sync_err_o}, 32'd0);
        chk("s1_idle", {31'h0, busy_o}, 32'd0);

        // backpressure
        code_ready_i = 1'b0;
        do_start();
        repeat (12) tick();
        chk("s2_acc_stall", n_acc, 32'd4);
        chk("s2_ready_low", {31'h0, pix_ready_o}, 32'd0);
        chk("s2_no_codes", n_codes, 32'd0);
        chk("s2_valid", {31'h0, code_valid_o}, 32'd1);
        code_ready_i = 1'b1;
        wait_frame(500);
        chk("s2_codes", n_codes, 32'd30);
        chk("s2_queue", exp_q.size(), 32'd0);

        // sync fault
        tick();
        drop_r = 2;
        drop_c = 3;
        do_start();
        wait_frame(500);
        drop_r = -1;
        drop_c = -1;
        chk("s3_codes", n_codes, 32'd30);
        chk("s3_code23", {24'h0, seen[15]}, 32'h23);
        chk("s3_err_time", err_cyc - drop_acc, 32'd4);
        tick();
        chk("s3_err_held", {31'h0, sync_err_o}, 32'd1);

        // start while running / draining, random valid
        rnd = 1'b1;
        do_start();
        tick();
        chk("s5_err_cleared", {31'h0, sync_err_o}, 32'd0);
        wait_acc(5, 500);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_acc(30, 1000);
        tick();
        chk("s5_drain_busy", {31'h0, busy_o}, 32'd1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_frame(500);
        rnd = 1'b0;
        pix_valid_i = 1'b1;
        repeat (5) tick();
        chk("s5_frames", n_frame, 32'd1);
        chk("s5_acc", n_acc, 32'd30);
        chk("s5_codes", n_codes, 32'd30);
        chk("s5_idle", {31'h0, busy_o}, 32'd0);

        // reset mid-frame
        do_start();
        wait_acc(10, 500);
        rst = 1'b0;
        #1;
        chk_zero("s4_reset_outputs");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        do_start();
        wait_frame(500);
        repeat (2) tick();
        chk("s4_codes", n_codes, 32'd30);
        chk("s4_frames", n_frame, 32'd1);
        chk("s4_queue", exp_q.size(), 32'd0);
        chk("s4_sync_err", {31'h0, sync_err_o}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
